// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the PC / instruction-fetch slice.
package pc_fetch_pkg;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} fetch_state_t;

    typedef logic [31:0] word_t;

    localparam word_t       RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

endpackage

// File: rtl/pc_register.sv
// Program counter register with async active-low reset and word alignment.
// With PC_FETCH_MISALIGN_CHECK_EN a misaligned load is flagged and suppressed.
module pc_register
    import pc_fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic  clk,
    input  logic  rstN,
    input  logic  load,
    input  word_t d,
    output word_t q
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    ,
    output logic  misaligned
`endif
);

    logic  do_load;
    word_t d_aligned;

    // Low bits are forced to zero; with the check enabled they are already zero when a load happens.
    assign d_aligned = d & 32'hFFFF_FFFC;

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    assign misaligned = load && (d[1:0] != 2'b00);
    assign do_load    = load && !misaligned;
`else
    assign do_load    = load;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)        q <= RESET_PC;
        else if (do_load) q <= d_aligned;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and single-outstanding instruction fetcher feeding decode over valid/ready.
// Optional misaligned-PC halt is enabled by PC_FETCH_MISALIGN_CHECK_EN.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter word_t       RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic  clk,
    input  logic  rstN,
    input  word_t pcNext,
    input  logic  redirect,
    output word_t pcAdd,
    output logic  imemReq,
    output word_t imemAddr,
    input  logic  imemGnt,
    input  logic  imemRspValid,
    input  word_t imemRspData,
    output logic  instrValid,
    output word_t instr,
    output word_t instrPc,
    input  logic  instrReady
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    ,
    output logic  misalignFault
`endif
);

    fetch_state_t state, state_n;
    logic         discard, discard_n;
    logic         pc_load;
    logic         latch_rsp;
    word_t        pc;
    logic         pc_bad;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .rstN       (rstN),
        .load       (pc_load),
        .d          (pcNext),
        .q          (pc)
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        ,
        .misaligned (pc_bad)
`endif
    );

`ifndef PC_FETCH_MISALIGN_CHECK_EN
    assign pc_bad = 1'b0;
`endif

    assign pcAdd      = pc + word_t'(PC_STEP);
    assign imemAddr   = pc;
    assign imemReq    = (state == S_REQ);
    assign instrValid = (state == S_OUT);

    always_comb begin
        state_n   = state;
        discard_n = discard;
        pc_load   = 1'b0;
        latch_rsp = 1'b0;
        case (state)
            S_REQ: begin
                if (imemGnt) begin
                    state_n   = S_WAIT;
                    discard_n = redirect;
                end
            end
            S_WAIT: begin
                if (imemRspValid) begin
                    // A redirect arriving with the response kills it just like a pending discard.
                    latch_rsp = !(discard || redirect);
                    state_n   = latch_rsp ? S_OUT : S_REQ;
                    discard_n = 1'b0;
                end else if (redirect) begin
                    discard_n = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    state_n = S_REQ;
                end else if (instrReady) begin
                    state_n = S_REQ;
                    pc_load = 1'b1;
                end
            end
            default: ;
        endcase
        if (redirect && state != S_HALT) pc_load = 1'b1;
        if (pc_bad) begin
            state_n   = S_HALT;
            latch_rsp = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= S_REQ;
            discard <= 1'b0;
            instr   <= '0;
            instrPc <= '0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
            if (latch_rsp) begin
                instr   <= imemRspData;
                instrPc <= pc;
            end
        end
    end

`ifdef PC_FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)       misalignFault <= 1'b0;
        else if (pc_bad) misalignFault <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: behavioural imem, selector stand-in and handshake scoreboard.
module tb_pc_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] load;
        logic [31:0] addr;
        logic [31:0] add;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] pcNext;
    logic        redirect;
    logic [31:0] pcAdd;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRspValid;
    logic [31:0] imemRspData;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic        instrReady;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    logic        misalignFault;
`endif

    int total = 0;
    int bad   = 0;

    exp_t        sb_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] tgt;
    logic        gnt_en;
    int          rsp_delay;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    int          hs_cnt;
    logic [31:0] last_hs_pc;

    pc_fetch_unit dut (
        .clk          (clk),
        .rstN         (rstN),
        .pcNext       (pcNext),
        .redirect     (redirect),
        .pcAdd        (pcAdd),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemGnt      (imemGnt),
        .imemRspValid (imemRspValid),
        .imemRspData  (imemRspData),
        .instrValid   (instrValid),
        .instr        (instr),
        .instrPc      (instrPc),
        .instrReady   (instrReady)
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        ,
        .misalignFault(misalignFault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail_timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s timeout", nm);
    endtask

    // One clock: outputs observed and inputs driven at the falling edge.
    task automatic cyc();
        exp_t e;
        if (instrValid && instrReady && !redirect) begin
            if (sb_q.size() == 0) begin
                fail_timeout("unexpected_instr");
            end else begin
                e = sb_q.pop_front();
                chk("hs_instrPc", instrPc, e.pc);
                chk("hs_instr", instr, e.word);
            end
            hs_cnt++;
            last_hs_pc = instrPc;
        end
        pcNext       = redirect ? tgt : pcAdd;
        imemRspValid = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                imemRspValid = 1'b1;
                imemRspData  = mem_word(paddr);
                pend         = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (redirect) sb_q.delete();
        imemGnt = gnt_en && imemReq && rstN;
        if (imemGnt) begin
            pend  = 1'b1;
            cnt   = rsp_delay;
            paddr = imemAddr;
            gnt_log.push_back(imemAddr);
            if (!redirect) sb_q.push_back('{pc: imemAddr, word: mem_word(imemAddr)});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_hs(input string nm);
        int start;
        int n;
        start = hs_cnt;
        n     = 0;
        while (hs_cnt == start && n < 40) begin
            cyc();
            n++;
        end
        if (hs_cnt == start) fail_timeout(nm);
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!instrValid && n < 20) begin
            cyc();
            n++;
        end
        chk(nm, {31'b0, instrValid}, 32'd1);
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] hold_i;
        logic [31:0] hold_p;
        int          n;

        vecs[0] = '{load: 32'h0000_0100, addr: 32'h0000_0100, add: 32'h0000_0104};
        vecs[1] = '{load: 32'hFFFF_FFFC, addr: 32'hFFFF_FFFC, add: 32'h0000_0000};
        vecs[2] = '{load: 32'h1234_5678, addr: 32'h1234_5678, add: 32'h1234_567C};
        vecs[3] = '{load: 32'h7FFF_FFFC, addr: 32'h7FFF_FFFC, add: 32'h8000_0000};
        vecs[4] = '{load: 32'h0000_0000, addr: 32'h0000_0000, add: 32'h0000_0004};

        rstN = 1'b0; redirect = 1'b0; tgt = '0; pcNext = '0;
        imemGnt = 1'b0; imemRspValid = 1'b0; imemRspData = '0;
        instrReady = 1'b1; gnt_en = 1'b1; rsp_delay = 1;
        pend = 1'b0; cnt = 0; paddr = '0; hs_cnt = 0; last_hs_pc = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_instrValid", {31'b0, instrValid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instrPc", instrPc, 32'h0);
        chk("rst_imemAddr", imemAddr, 32'h0);
        chk("rst_pcAdd", pcAdd, 32'h4);
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        chk("rst_fault", {31'b0, misalignFault}, 32'd0);
`endif
        rstN = 1'b1;
        chk("rel_imemReq", {31'b0, imemReq}, 32'd1);

        // sequential fetch stream
        gnt_log.delete();
        for (int i = 0; i < 3; i++) run_until_hs("t1_hs");
        chk("t1_nreq", gnt_log.size() >= 3 ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 3 && i < gnt_log.size(); i++)
            chk("t1_addr", gnt_log[i], 32'(4 * i));

        // redirect while waiting for the response
        rsp_delay = 2;
        cyc();
        redirect = 1'b1; tgt = 32'h100;
        cyc();
        redirect = 1'b0;
        cyc();
        chk("t2_novalid", {31'b0, instrValid}, 32'd0);
        chk("t2_req", {31'b0, imemReq}, 32'd1);
        chk("t2_addr", imemAddr, 32'h100);
        rsp_delay = 1;
        run_until_hs("t2_hs");
        chk("t2_hs_pc", last_hs_pc, 32'h100);

        // decode stall holds the buffer
        instrReady = 1'b0;
        wait_valid("t3_valid");
        hold_i = instr;
        hold_p = instrPc;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_instr", instr, hold_i);
            chk("t3_instrPc", instrPc, hold_p);
            chk("t3_noreq", {31'b0, imemReq}, 32'd0);
        end
        instrReady = 1'b1;
        cyc();
        chk("t3_req", {31'b0, imemReq}, 32'd1);
        chk("t3_addr", imemAddr, hold_p + 32'd4);

        // reset in the middle of a wait, late response afterwards
        rsp_delay = 3;
        cyc();
        rstN = 1'b0;
        #1;
        chk("t4_valid_now", {31'b0, instrValid}, 32'd0);
        chk("t4_addr_now", imemAddr, 32'h0);
        sb_q.delete();
        gnt_en = 1'b0;
        cyc();
        rstN = 1'b1;
        n = 0;
        while (pend && n < 10) begin
            cyc();
            chk("t4_novalid", {31'b0, instrValid}, 32'd0);
            n++;
        end
        if (pend) fail_timeout("t4_rsp");
        cyc();
        chk("t4_ignored", {31'b0, instrValid}, 32'd0);
        chk("t4_req", {31'b0, imemReq}, 32'd1);
        chk("t4_addr", imemAddr, 32'h0);
        gnt_en = 1'b1; rsp_delay = 1;
        run_until_hs("t4_hs");
        chk("t4_hs_pc", last_hs_pc, 32'h0);

        // pcAdd table, including the 32-bit wrap
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            redirect = 1'b1; tgt = vecs[i].load;
            cyc();
            redirect = 1'b0;
            chk("t5_addr", imemAddr, vecs[i].addr);
            chk("t5_pcAdd", pcAdd, vecs[i].add);
        end

        // redirect together with grant drops the following response
        gnt_en = 1'b1;
        redirect = 1'b1; tgt = 32'h200;
        cyc();
        redirect = 1'b0;
        cyc();
        chk("t5_drop", {31'b0, instrValid}, 32'd0);
        chk("t5_req", {31'b0, imemReq}, 32'd1);
        chk("t5_addr200", imemAddr, 32'h200);
        run_until_hs("t5_hs");
        chk("t5_hs_pc", last_hs_pc, 32'h200);

        // redirect while an instruction is offered
        instrReady = 1'b0;
        wait_valid("t5_out_valid");
        redirect = 1'b1; tgt = 32'h300; instrReady = 1'b1;
        cyc();
        redirect = 1'b0;
        chk("t5_out_flush", {31'b0, instrValid}, 32'd0);
        chk("t5_out_addr", imemAddr, 32'h300);
        run_until_hs("t5_out_hs");
        chk("t5_out_hs_pc", last_hs_pc, 32'h300);

        // misaligned redirect target
        gnt_en = 1'b0;
        redirect = 1'b1; tgt = 32'h102;
        cyc();
        redirect = 1'b0;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
        chk("t6_fault", {31'b0, misalignFault}, 32'd1);
        chk("t6_pc_kept", imemAddr, 32'h304);
        gnt_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_noreq", {31'b0, imemReq}, 32'd0);
            chk("t6_novalid", {31'b0, instrValid}, 32'd0);
            cyc();
        end
`else
        chk("t6_aligned", imemAddr, 32'h100);
        chk("t6_req", {31'b0, imemReq}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
